// File: rtl/alu_arbiter.sv
// Two-requester front end for a shared combinational ALU: round-robin accept,
// one transaction in flight, result held until the owning requester takes it.
module alu_arbiter #(
  parameter bit RR_INIT = 1'b0
) (
  input  logic        I_CLK,
  input  logic        I_NRESET,
  input  logic        I_REQ0_VALID,
  input  logic        I_REQ1_VALID,
  output logic        O_REQ0_READY,
  output logic        O_REQ1_READY,
  input  logic [3:0]  I_REQ0_OPCODE,
  input  logic [3:0]  I_REQ1_OPCODE,
  input  logic [15:0] I_REQ0_A,
  input  logic [15:0] I_REQ0_B,
  input  logic [15:0] I_REQ1_A,
  input  logic [15:0] I_REQ1_B,
  output logic        O_RSP0_VALID,
  output logic        O_RSP1_VALID,
  input  logic        I_RSP0_READY,
  input  logic        I_RSP1_READY,
  output logic [15:0] O_RSP_C,
  output logic [4:0]  O_RSP_STATUS,
  output logic        O_RSP_ERR,
  output logic [3:0]  O_ALU_OPCODE,
  output logic [15:0] O_ALU_A,
  output logic [15:0] O_ALU_B,
  input  logic [15:0] I_ALU_C,
  input  logic [4:0]  I_ALU_STATUS,
  output logic        O_BUSY
);
  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} state_t;

  state_t      state;
  logic        ptr;
  logic        owner;
  logic [3:0]  opcode;
  logic [15:0] op_a;
  logic [15:0] op_b;
  logic        grant0;
  logic        grant1;

  // Opcodes 12..15 have no ALU meaning and complete with ERR set.
  function automatic logic illegal_op(input logic [3:0] op);
    return op[3] & op[2];
  endfunction

  // ptr names the requester that wins when both are valid.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (state == IDLE) begin
      if (I_REQ0_VALID && (!I_REQ1_VALID || !ptr)) grant0 = 1'b1;
      else if (I_REQ1_VALID)                      grant1 = 1'b1;
    end
  end

  assign O_REQ0_READY = grant0;
  assign O_REQ1_READY = grant1;
  assign O_ALU_OPCODE = opcode;
  assign O_ALU_A      = op_a;
  assign O_ALU_B      = op_b;

  always_ff @(posedge I_CLK) begin
    if (!I_NRESET) begin
      state        <= IDLE;
      ptr          <= RR_INIT;
      owner        <= 1'b0;
      opcode       <= 4'd0;
      op_a         <= 16'd0;
      op_b         <= 16'd0;
      O_RSP0_VALID <= 1'b0;
      O_RSP1_VALID <= 1'b0;
      O_RSP_C      <= 16'd0;
      O_RSP_STATUS <= 5'd0;
      O_RSP_ERR    <= 1'b0;
      O_BUSY       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant0 || grant1) begin
            owner  <= grant1;
            ptr    <= grant0;
            opcode <= grant1 ? I_REQ1_OPCODE : I_REQ0_OPCODE;
            op_a   <= grant1 ? I_REQ1_A : I_REQ0_A;
            op_b   <= grant1 ? I_REQ1_B : I_REQ0_B;
            O_BUSY <= 1'b1;
            state  <= EXEC;
          end
        end
        EXEC: begin
          if (illegal_op(opcode)) begin
            O_RSP_C      <= 16'd0;
            O_RSP_STATUS <= 5'd0;
            O_RSP_ERR    <= 1'b1;
          end else begin
            O_RSP_C      <= I_ALU_C;
            O_RSP_STATUS <= I_ALU_STATUS;
            O_RSP_ERR    <= 1'b0;
          end
          O_RSP0_VALID <= !owner;
          O_RSP1_VALID <= owner;
          state        <= RESP;
        end
        RESP: begin
          // Only the owner's ready matters; the result holds until it is taken.
          if (owner ? I_RSP1_READY : I_RSP0_READY) begin
            O_RSP0_VALID <= 1'b0;
            O_RSP1_VALID <= 1'b0;
            O_BUSY       <= 1'b0;
            state        <= IDLE;
          end
        end
        default: begin
          O_RSP0_VALID <= 1'b0;
          O_RSP1_VALID <= 1'b0;
          O_BUSY       <= 1'b0;
          state        <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: a behavioural ALU sits on the ALU port,
// per-requester queues hold expected results until the response handshake.
module tb_alu_arbiter;
  logic        clk = 1'b0;
  logic        nreset;
  logic        req0_valid, req1_valid, req0_ready, req1_ready;
  logic [3:0]  req0_op, req1_op;
  logic [15:0] req0_a, req0_b, req1_a, req1_b;
  logic        rsp0_valid, rsp1_valid, rsp0_ready, rsp1_ready;
  logic [15:0] rsp_c;
  logic [4:0]  rsp_status;
  logic        rsp_err;
  logic [3:0]  alu_op;
  logic [15:0] alu_a, alu_b, alu_c;
  logic [4:0]  alu_status;
  logic        busy;

  typedef struct {
    logic [15:0] c;
    logic [4:0]  st;
    logic        err;
  } exp_t;

  exp_t        q0[$];
  exp_t        q1[$];
  int          acc_log[$];
  longint      acc_t0[$];
  int          total = 0;
  int          bad = 0;
  logic [15:0] last_c0, last_c1;
  logic        last_err0;
  exp_t        mon_e;

  always #5 clk = ~clk;

  alu_arbiter #(.RR_INIT(1'b0)) dut (
    .I_CLK(clk), .I_NRESET(nreset),
    .I_REQ0_VALID(req0_valid), .I_REQ1_VALID(req1_valid),
    .O_REQ0_READY(req0_ready), .O_REQ1_READY(req1_ready),
    .I_REQ0_OPCODE(req0_op), .I_REQ1_OPCODE(req1_op),
    .I_REQ0_A(req0_a), .I_REQ0_B(req0_b), .I_REQ1_A(req1_a), .I_REQ1_B(req1_b),
    .O_RSP0_VALID(rsp0_valid), .O_RSP1_VALID(rsp1_valid),
    .I_RSP0_READY(rsp0_ready), .I_RSP1_READY(rsp1_ready),
    .O_RSP_C(rsp_c), .O_RSP_STATUS(rsp_status), .O_RSP_ERR(rsp_err),
    .O_ALU_OPCODE(alu_op), .O_ALU_A(alu_a), .O_ALU_B(alu_b),
    .I_ALU_C(alu_c), .I_ALU_STATUS(alu_status), .O_BUSY(busy)
  );

  // Returns {negative, zero, flag, low, carry, c}; illegal opcodes give junk.
  function automatic logic [20:0] alu_model(input logic [3:0] op, input logic [15:0] a,
                                            input logic [15:0] b);
    logic [16:0] w;
    logic [31:0] m;
    logic [15:0] c;
    logic        cy, fl;
    w = 17'd0; m = 32'd0; c = 16'd0; cy = 1'b0; fl = 1'b0;
    case (op)
      4'd0: begin w = {1'b0, a} + {1'b0, b}; c = w[15:0]; cy = w[16];
                  fl = (a[15] == b[15]) && (c[15] != a[15]); end
      4'd1: begin w = {1'b0, a} + {1'b0, b} + 17'd1; c = w[15:0]; cy = w[16];
                  fl = (a[15] == b[15]) && (c[15] != a[15]); end
      4'd2: begin m = 32'(a) * 32'(b); c = m[15:0]; fl = |m[31:16]; end
      4'd3: begin w = {1'b0, b} - {1'b0, a}; c = w[15:0]; cy = w[16];
                  fl = (a[15] != b[15]) && (c[15] != b[15]); end
      4'd4: c = ~a;
      4'd5: c = a & b;
      4'd6: c = a | b;
      4'd7: c = a ^ b;
      4'd8: c = a << b[3:0];
      4'd9: c = a >> b[3:0];
      4'd10: c = a <<< b[3:0];
      4'd11: c = 16'($signed(a) >>> b[3:0]);
      default: return {5'h1F, 16'hDEAD};
    endcase
    return {c[15], (c == 16'd0), fl, c[0], cy, c};
  endfunction

  assign {alu_status, alu_c} = alu_model(alu_op, alu_a, alu_b);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, want);
    end
  endtask

  // Drives one request, holds VALID until accepted, then drops it.
  task automatic send(input int n, input logic [3:0] op, input logic [15:0] a,
                      input logic [15:0] b);
    exp_t        e;
    logic [20:0] r;
    bit          done;
    r     = alu_model(op, a, b);
    e.err = (op >= 4'd12);
    e.c   = e.err ? 16'd0 : r[15:0];
    e.st  = e.err ? 5'd0 : r[20:16];
    if (n == 0) begin
      q0.push_back(e); req0_op = op; req0_a = a; req0_b = b; req0_valid = 1'b1;
    end else begin
      q1.push_back(e); req1_op = op; req1_a = a; req1_b = b; req1_valid = 1'b1;
    end
    done = 1'b0;
    for (int k = 0; k < 300 && !done; k++) begin
      #1;
      done = (n == 0) ? req0_ready : req1_ready;
      @(posedge clk);
      if (done) begin
        acc_log.push_back(n);
        if (n == 0) acc_t0.push_back($time);
      end
      #1;
    end
    if (n == 0) req0_valid = 1'b0; else req1_valid = 1'b0;
    if (!done) check("accept_timeout", (n == 0) ? req0_ready : req1_ready, 1);
  endtask

  task automatic wait_drain();
    int pending;
    pending = 1;
    for (int k = 0; k < 300 && pending != 0; k++) begin
      @(posedge clk); #1;
      pending = q0.size() + q1.size() + int'(req0_valid) + int'(req1_valid) + int'(busy);
    end
    if (pending != 0) check("drain_timeout", pending, 0);
  endtask

  always @(negedge clk) begin
    if (nreset) begin
      if (req0_valid && req1_valid) check("ready_excl", req0_ready & req1_ready, 0);
      check("rsp_vld_excl", rsp0_valid & rsp1_valid, 0);
      if (rsp0_valid && rsp0_ready) begin
        if (q0.size() == 0) check("rsp0_unexpected", rsp0_valid, 0);
        else begin
          mon_e = q0.pop_front();
          check("rsp0_c", rsp_c, mon_e.c);
          check("rsp0_status", rsp_status, mon_e.st);
          check("rsp0_err", rsp_err, mon_e.err);
          last_c0 = rsp_c; last_err0 = rsp_err;
        end
      end
      if (rsp1_valid && rsp1_ready) begin
        if (q1.size() == 0) check("rsp1_unexpected", rsp1_valid, 0);
        else begin
          mon_e = q1.pop_front();
          check("rsp1_c", rsp_c, mon_e.c);
          check("rsp1_status", rsp_status, mon_e.st);
          check("rsp1_err", rsp_err, mon_e.err);
          last_c1 = rsp_c;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] hold_c;
    logic [4:0]  hold_st;
    nreset = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_op = 4'd0; req1_op = 4'd0;
    req0_a = 16'd0; req0_b = 16'd0; req1_a = 16'd0; req1_b = 16'd0;
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_rsp_vld", {rsp0_valid, rsp1_valid}, 0);
    check("rst_rsp", {rsp_c, rsp_status, rsp_err}, 0);
    check("rst_alu", {alu_op, alu_a, alu_b}, 0);

    // Contention straight out of reset: req0 first, then req1.
    nreset = 1'b1; rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    acc_log.delete();
    fork
      send(0, 4'd3, 16'd5, 16'd3);
      send(1, 4'd2, 16'd3, 16'd4);
    join
    wait_drain();
    check("cont_n", acc_log.size(), 2);
    if (acc_log.size() == 2) begin
      check("cont_first", acc_log[0], 0);
      check("cont_second", acc_log[1], 1);
    end
    check("cont_c0", last_c0, 16'hFFFE);
    check("cont_c1", last_c1, 16'h000C);

    // Sustained contention alternates winners.
    acc_log.delete();
    fork
      begin send(0, 4'd5, 16'hF0F0, 16'h3C3C); send(0, 4'd8, 16'h0001, 16'd4); end
      begin send(1, 4'd7, 16'h1234, 16'hFFFF); send(1, 4'd11, 16'h8000, 16'd3); end
    join
    wait_drain();
    check("alt_n", acc_log.size(), 4);
    for (int i = 0; i < 4 && i < acc_log.size(); i++) check("alt_order", acc_log[i], i % 2);

    // Single ADD with overflow flag.
    send(0, 4'd0, 16'h7FFF, 16'h0001);
    check("add_exec_vld", rsp0_valid, 0);
    @(posedge clk); #1;
    check("add_rsp_vld", rsp0_valid, 1);
    check("add_c", rsp_c, 16'h8000);
    check("add_flag", rsp_status[2], 1);
    check("add_err", rsp_err, 0);
    wait_drain();

    // Response backpressure on requester 1 while requester 0 waits.
    rsp1_ready = 1'b0;
    send(1, 4'd6, 16'h00F0, 16'h0F00);
    fork
      send(0, 4'd9, 16'h8000, 16'd15);
    join_none
    @(posedge clk); #1;
    hold_c = rsp_c; hold_st = rsp_status;
    check("bp_c_val", hold_c, 16'h0FF0);
    for (int i = 0; i < 5; i++) begin
      check("bp_vld", rsp1_valid, 1);
      check("bp_c", rsp_c, hold_c);
      check("bp_status", rsp_status, hold_st);
      check("bp_req0_ready", req0_ready, 0);
      @(posedge clk); #1;
    end
    rsp1_ready = 1'b1;
    wait_drain();

    // Illegal opcode then a legal one.
    send(0, 4'hC, 16'h1111, 16'h2222);
    wait_drain();
    check("inv_err", last_err0, 1);
    check("inv_c", last_c0, 0);
    send(1, 4'hF, 16'h0001, 16'h0002);
    send(0, 4'd7, 16'hAAAA, 16'h5555);
    wait_drain();
    check("inv_next_err", last_err0, 0);
    check("inv_next_c", last_c0, 16'hFFFF);

    // Reset pulse during EXEC aborts the transaction and restores the pointer.
    send(0, 4'd0, 16'd3, 16'd4);
    nreset = 1'b0;
    @(posedge clk); #1;
    nreset = 1'b1;
    q0.delete();
    check("mid_busy", busy, 0);
    check("mid_rsp", {rsp0_valid, rsp1_valid, rsp_c, rsp_status, rsp_err}, 0);
    check("mid_alu", {alu_op, alu_a, alu_b}, 0);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check("mid_no_rsp", {rsp0_valid, rsp1_valid}, 0);
    end
    acc_log.delete();
    fork
      send(1, 4'd4, 16'h00FF, 16'd0);
      send(0, 4'd1, 16'hFFFF, 16'd0);
    join
    wait_drain();
    if (acc_log.size() > 0) check("mid_ptr_first", acc_log[0], 0);
    else check("mid_ptr_n", acc_log.size(), 2);

    // Streaming on requester 0: one accept every three cycles.
    acc_t0.delete();
    send(0, 4'd0, 16'd1, 16'd2);
    send(0, 4'd3, 16'd10, 16'd7);
    send(0, 4'd2, 16'h0100, 16'h0100);
    send(0, 4'd10, 16'h4001, 16'd1);
    wait_drain();
    check("stream_n", acc_t0.size(), 4);
    for (int i = 1; i < acc_t0.size(); i++)
      check("stream_gap", 32'(acc_t0[i] - acc_t0[i-1]), 30);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
